// File: rtl/answer_checker_if.sv
// Handshake and player-facing signal bundle for answer_checker.
// master drives generator/player inputs, slave is the checker itself.
interface answer_checker_if;
  logic       start;
  logic       gen_enable;
  logic       target_valid;
  logic [3:0] target;
  logic       target_ready;
  logic [3:0] guess;
  logic       submit;
  logic       correct;
  logic       wrong;
  logic       timeout;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic [3:0] target_q;

  modport master (
    output start, target_valid, target, guess, submit,
    input  gen_enable, target_ready, correct, wrong, timeout,
           score, lives, game_over, target_q
  );

  modport slave (
    input  start, target_valid, target, guess, submit,
    output gen_enable, target_ready, correct, wrong, timeout,
           score, lives, game_over, target_q
  );
endinterface

// File: rtl/answer_checker.sv
// Round controller for the binary-number game: fetches a target, judges guesses, keeps score/lives.
// Define ANSWER_CHECKER_TIMEOUT_EN to build the per-round timer; otherwise timeout is tied low.
//
// state   | meaning
// S_IDLE  | after reset, waiting for start
// S_FETCH | requesting a target from the generator
// S_ARMED | target captured, waiting for a submit edge (or timer expiry)
// S_JUDGE | one cycle comparing latched guess to target
// S_OVER  | lives exhausted, results held until start
module answer_checker #(
  parameter int LIVES        = 3,
  parameter int ROUND_CYCLES = 50_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  answer_checker_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ARMED, S_JUDGE, S_OVER} state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  if (ROUND_CYCLES < 2) begin : g_bad_round_cycles
    $error("answer_checker: ROUND_CYCLES must be at least 2");
  end

  state_t     r_state;
  logic       r_submit_q;
  logic [3:0] r_guess_q;
  logic [3:0] r_target_q;
  logic [7:0] r_score;
  logic [1:0] r_lives;
  logic       r_gen_enable;
  logic       r_target_ready;
  logic       r_correct;
  logic       r_wrong;
  logic       r_game_over;

  logic       w_submit_edge;
  logic [1:0] w_lives_dec;

  assign w_submit_edge = bus.submit && !r_submit_q;
  assign w_lives_dec   = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;

`ifdef ANSWER_CHECKER_TIMEOUT_EN
  localparam int          TW         = (ROUND_CYCLES > 2) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ROUND_CYCLES - 1);

  logic [TW-1:0] r_timer;
  logic          r_timeout;

  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_submit_q     <= 1'b0;
      r_guess_q      <= 4'd0;
      r_target_q     <= 4'd0;
      r_score        <= 8'd0;
      r_lives        <= 2'd0;
      r_gen_enable   <= 1'b0;
      r_target_ready <= 1'b0;
      r_correct      <= 1'b0;
      r_wrong        <= 1'b0;
      r_game_over    <= 1'b0;
`ifdef ANSWER_CHECKER_TIMEOUT_EN
      r_timer        <= '0;
      r_timeout      <= 1'b0;
`endif
    end else begin
      r_submit_q <= bus.submit;
      r_correct  <= 1'b0;
      r_wrong    <= 1'b0;
`ifdef ANSWER_CHECKER_TIMEOUT_EN
      r_timeout  <= 1'b0;
`endif
      case (r_state)
        S_IDLE, S_OVER: begin
          if (bus.start) begin
            r_state        <= S_FETCH;
            r_score        <= 8'd0;
            r_lives        <= LIVES_INIT;
            r_gen_enable   <= 1'b1;
            r_target_ready <= 1'b1;
            r_game_over    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (bus.target_valid) begin
            r_state        <= S_ARMED;
            r_target_q     <= bus.target;
            r_gen_enable   <= 1'b0;
            r_target_ready <= 1'b0;
`ifdef ANSWER_CHECKER_TIMEOUT_EN
            r_timer        <= TIMER_LOAD;
`endif
          end
        end
        S_ARMED: begin
          // A submit edge takes priority over a timer that has just run out.
          if (w_submit_edge) begin
            r_state   <= S_JUDGE;
            r_guess_q <= bus.guess;
`ifdef ANSWER_CHECKER_TIMEOUT_EN
          end else if (r_timer == '0) begin
            r_timeout <= 1'b1;
            r_lives   <= w_lives_dec;
            if (w_lives_dec == 2'd0) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state        <= S_FETCH;
              r_gen_enable   <= 1'b1;
              r_target_ready <= 1'b1;
            end
          end else begin
            r_timer <= r_timer - TW'(1);
`endif
          end
        end
        S_JUDGE: begin
          if (r_guess_q == r_target_q) begin
            r_correct      <= 1'b1;
            r_score        <= (r_score == 8'hFF) ? 8'hFF : r_score + 8'd1;
            r_state        <= S_FETCH;
            r_gen_enable   <= 1'b1;
            r_target_ready <= 1'b1;
          end else begin
            r_wrong <= 1'b1;
            r_lives <= w_lives_dec;
            if (w_lives_dec == 2'd0) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state        <= S_FETCH;
              r_gen_enable   <= 1'b1;
              r_target_ready <= 1'b1;
            end
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_gen_enable   <= 1'b0;
          r_target_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gen_enable   = r_gen_enable;
  assign bus.target_ready = r_target_ready;
  assign bus.correct      = r_correct;
  assign bus.wrong        = r_wrong;
  assign bus.score        = r_score;
  assign bus.lives        = r_lives;
  assign bus.game_over    = r_game_over;
  assign bus.target_q     = r_target_q;

endmodule

// File: tb/tb_answer_checker.sv
// Self-checking bench for answer_checker: game-level reference model plus directed literal checks.
// Timer scenarios run when ANSWER_CHECKER_TIMEOUT_EN is defined, the no-timer wait scenario otherwise.
module tb_answer_checker;
  localparam int LIVES = 3;
  localparam int RC    = 8;
`ifdef ANSWER_CHECKER_TIMEOUT_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  localparam int MD_IDLE  = 0;
  localparam int MD_FETCH = 1;
  localparam int MD_ARMED = 2;
  localparam int MD_JUDGE = 3;
  localparam int MD_OVER  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  answer_checker_if bus ();

  answer_checker #(.LIVES(LIVES), .ROUND_CYCLES(RC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Game-level model: which phase the player is in, what has been scored, what was lost.
  int m_mode = MD_IDLE;
  int m_score = 0, m_lives = 0, m_tq = 0, m_guess = 0, m_armed = 0;
  bit m_sub_prev = 1'b0, m_correct = 1'b0, m_wrong = 1'b0, m_timeout = 1'b0;

  function void lose_life();
    if (m_lives > 0) m_lives--;
    m_mode = (m_lives == 0) ? MD_OVER : MD_FETCH;
  endfunction

  always @(posedge clk) begin
    bit edge_seen;
    m_correct = 1'b0;
    m_wrong   = 1'b0;
    m_timeout = 1'b0;
    if (!rst_n) begin
      m_mode = MD_IDLE; m_score = 0; m_lives = 0; m_tq = 0; m_guess = 0;
      m_armed = 0; m_sub_prev = 1'b0;
    end else begin
      edge_seen  = bus.submit && !m_sub_prev;
      m_sub_prev = bus.submit;
      case (m_mode)
        MD_IDLE, MD_OVER:
          if (bus.start) begin m_mode = MD_FETCH; m_score = 0; m_lives = LIVES; end
        MD_FETCH:
          if (bus.target_valid) begin m_tq = int'(bus.target); m_mode = MD_ARMED; m_armed = 0; end
        MD_ARMED:
          if (edge_seen) begin m_guess = int'(bus.guess); m_mode = MD_JUDGE; end
          else if (TIMER_ON && m_armed == RC - 1) begin m_timeout = 1'b1; lose_life(); end
          else m_armed++;
        MD_JUDGE:
          if (m_guess == m_tq) begin
            m_correct = 1'b1;
            if (m_score < 255) m_score++;
            m_mode = MD_FETCH;
          end else begin
            m_wrong = 1'b1;
            lose_life();
          end
        default: m_mode = MD_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    logic [22:0] exp_v, act_v;
    #1;
    exp_v = {m_mode == MD_FETCH, m_mode == MD_FETCH, m_correct, m_wrong, m_timeout,
             8'(m_score), 2'(m_lives), m_mode == MD_OVER, 4'(m_tq)};
    act_v = {bus.gen_enable, bus.target_ready, bus.correct, bus.wrong, bus.timeout,
             bus.score, bus.lives, bus.game_over, bus.target_q};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cycle t=%0t actual{gen,rdy,cor,wr,to,score,lives,over,tq}=%b required=%b",
               $time, act_v, exp_v);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic capture(input logic [3:0] t);
    bus.target_valid = 1'b1;
    bus.target = t;
    cyc(1);
    bus.target_valid = 1'b0;
  endtask

  // Returns at the cycle where the judgement pulse should be visible.
  task automatic press(input logic [3:0] g);
    bus.guess  = g;
    bus.submit = 1'b1;
    cyc(1);
    bus.submit = 1'b0;
    cyc(1);
  endtask

  initial begin
    int found;
    int ncorr;
    bus.start = 1'b0; bus.target_valid = 1'b0; bus.target = 4'd0;
    bus.guess = 4'd0; bus.submit = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    check("reset_lives", bus.lives, 0);
    check("reset_score", bus.score, 0);
    check("reset_ready", bus.target_ready, 0);
    check("reset_over", bus.game_over, 0);
    rst_n = 1'b1;
    cyc(1);

    // First round: correct answer
    start_game();
    check("fetch_gen_enable", bus.gen_enable, 1);
    capture(4'b1010);
    check("captured_target", bus.target_q, 10);
    press(4'b1010);
    check("t1_correct", bus.correct, 1);
    check("t1_score", bus.score, 1);
    check("t1_lives", bus.lives, 3);
    check("t1_ready", bus.target_ready, 1);
    cyc(1);
    check("t1_pulse_width", bus.correct, 0);

    // Wrong answers to game over
    capture(4'd5); press(4'd6);
    check("t2_wrong1", bus.wrong, 1);
    check("t2_lives2", bus.lives, 2);
    capture(4'd5); press(4'd6);
    check("t2_lives1", bus.lives, 1);
    capture(4'hF); press(4'd0);
    check("t2_lives0", bus.lives, 0);
    check("t2_over", bus.game_over, 1);
    check("t2_score_held", bus.score, 1);
    press(4'd3);
    check("t2_ignored_wrong", bus.wrong, 0);
    check("t2_still_over", bus.game_over, 1);
    start_game();
    check("t2_restart_lives", bus.lives, 3);
    check("t2_restart_score", bus.score, 0);

    // Submit held across FETCH and capture
    bus.submit = 1'b1;
    cyc(2);
    capture(4'd7);
    cyc(5);
    check("t3_no_judge_score", bus.score, 0);
    check("t3_still_armed", bus.target_ready, 0);
    bus.submit = 1'b0;
    cyc(1);
    press(4'd7);
    check("t3_judged", bus.correct, 1);
    check("t3_score", bus.score, 1);

`ifdef ANSWER_CHECKER_TIMEOUT_EN
    capture(4'd2);
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (bus.timeout) begin found = k; break; end
    end
    check("t4_timeout_latency", found, RC);
    check("t4_lives", bus.lives, 2);
    capture(4'd2);
    cyc(RC - 1);
    press(4'd2);
    check("t4_edge_wins_correct", bus.correct, 1);
    check("t4_edge_wins_no_to", bus.timeout, 0);
    capture(4'd2);
    cyc(RC - 1);
    press(4'd3);
    check("t4_edge_wins_wrong", bus.wrong, 1);
    check("t4_lives_after_wrong", bus.lives, 1);
`endif

    // Score saturation
    ncorr = 0;
    for (int i = 0; i < 256; i++) begin
      capture(4'(i));
      press(4'(i));
      if (bus.correct === 1'b1) ncorr++;
    end
    check("t5_score_sat", bus.score, 255);
    check("t5_correct_count", ncorr, 256);

    // Reset mid-round
    capture(4'd9);
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    check("t6_score", bus.score, 0);
    check("t6_lives", bus.lives, 0);
    check("t6_tq", bus.target_q, 0);
    check("t6_ready", bus.target_ready, 0);
    check("t6_pulses", {bus.correct, bus.wrong, bus.timeout}, 0);
    rst_n = 1'b1;
    cyc(1);

`ifndef ANSWER_CHECKER_TIMEOUT_EN
    start_game();
    capture(4'd3);
    cyc(10000);
    check("t7_no_timeout", bus.timeout, 0);
    check("t7_still_armed", bus.target_ready, 0);
    press(4'd3);
    check("t7_late_correct", bus.correct, 1);
`endif

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/answer_checker.md
# answer_checker

Consumer side of the binary-number game's number generator. Requests one 4-bit target from the generator per round, captures it, and waits for the player's switch value and submit button. It judges the guess, keeps score and lives, and ends the game when lives run out. Sits between the generator and the display/LED driver logic.

## Interface
- `LIVES`, 3: lives at game start; range 1–3.
- `ROUND_CYCLES`, 50_000_000: clock cycles allowed per round before timeout; must be ≥ 2.
- `clk  in  1`: system clock.
- `rst_n  in  1`: synchronous, active-low reset.
- `start  in  1`: level; starts a game from IDLE or OVER.
- `gen_enable  out  1`: drives the generator enable; high only in FETCH.
- `target_valid  in  1`: generator value is valid this cycle.
- `target  in  4`: generator value.
- `target_ready  out  1`: high only in FETCH; a capture occurs when `target_valid && target_ready`.
- `guess  in  4`: player switch value, already synchronised.
- `submit  in  1`: player button, already debounced; the block acts only on its rising edge.
- `correct  out  1`: one-cycle pulse when the guess equals the target.
- `wrong  out  1`: one-cycle pulse when the guess differs from the target.
- `timeout  out  1`: one-cycle pulse when the round expires.
- `score  out  8`: number of correct answers; saturates at 255.
- `lives  out  2`: remaining lives.
- `game_over  out  1`: high while in OVER.
- `target_q  out  4`: captured target, for display.

## Operation
- **States:** IDLE, FETCH, ARMED, JUDGE, OVER.
- **IDLE**
  - On `start`=1: go to FETCH, clear `score`, load `lives`=LIVES.
- **FETCH**
  - `gen_enable`=1 and `target_ready`=1.
  - On `target_valid`: load `target_q`=`target` and go to ARMED.
  - Stays in FETCH indefinitely without `target_valid`.
  - Submit edges are ignored and not remembered.
- **ARMED**
  - Submit edge is detected as `submit && !submit_q`, where `submit_q` is a register of `submit`.
  - On a submit edge: latch `guess` into `guess_q` and go to JUDGE.
- **JUDGE** (exactly one cycle)
  - If `guess_q == target_q`: pulse `correct` and increment `score`, saturating at 255.
  - Otherwise: pulse `wrong` and decrement `lives`.
  - Next state is OVER if `lives` becomes 0, else FETCH.
- **Timeout** (timer build only)
  - Pulse `timeout` and decrement `lives`.
  - Next state is OVER if `lives` becomes 0, else FETCH.
- **OVER**
  - `game_over`=1; `score`, `lives` and `target_q` are held.
  - On `start`=1: behave as IDLE with `start`.
- **Arithmetic**
  - `lives` never underflows; it only decrements while ≥ 1.
  - `score` add is unsigned with an explicit saturation check.
- **Bad parameters:** LIVES=0 is illegal; reset loads `lives`=0 and `start` still loads LIVES.

## Timing
- **Reset values:** state IDLE; `gen_enable`, `target_ready`, `correct`, `wrong`, `timeout`, `game_over` = 0; `score`=0; `lives`=0; `target_q`=0; `submit_q`=0; round timer = 0.
- **Output registering**
  - All outputs are registered.
  - Pulses are high for exactly one cycle.
  - `score` and `lives` update on the same edge that raises the pulse.
- **Submit latency:** `submit` first seen high at edge N while in ARMED → JUDGE after edge N → `correct`/`wrong` high after edge N+1 → FETCH (`target_ready`=1) in the same cycle as the pulse.
- **Capture latency:** capture at edge N → ARMED after edge N; the round timer loads ROUND_CYCLES-1 at that edge.
- **Round timer**
  - Decrements once per ARMED cycle.
  - When it is 0 in ARMED with no submit edge, `timeout` pulses after the next edge, giving exactly ROUND_CYCLES cycles in ARMED.
- **Simultaneous submit edge and timer at 0:** submit wins and no timeout occurs.
- **Submit held high across FETCH→ARMED:** no edge, so it does not count; the player must release and press again.
- **`rst_n`=0 mid-round:** all state returns to reset values at the next edge, with no pulse emitted.

## Configuration
- **`ANSWER_CHECKER_TIMEOUT_EN` defined:** the round timer, its `timeout` output behaviour and `ROUND_CYCLES` are implemented as above.
- **Undefined:**
  - No timer logic.
  - ARMED waits for a submit edge indefinitely.
  - The `timeout` port exists but is tied to 0.
  - `ROUND_CYCLES` is unused.

## Test plan
- **Reset and start:** reset, `start`=1, generator supplies `target`=4'b1010, `guess`=1010, submit pulse → `correct` pulse 2 edges after the submit edge, `score`=1, `lives`=3, `target_ready`=1 again.
- **Wrong answers to game over:** three rounds with wrong `guess` (LIVES=3) → three `wrong` pulses, `lives` 2, 1, 0, `game_over`=1; a further `submit` has no effect; `start` → `lives`=3, `score`=0.
- **Timeout:** with the macro defined and ROUND_CYCLES=8, capture a target and never submit → `timeout` pulses 8 cycles after capture, `lives` decrements; submit edge on the timer-0 cycle → `correct`/`wrong`, no `timeout`.
- **Held submit:** hold `submit`=1 through FETCH and the capture → no judgement; release, then press → judged once.
- **Score saturation:** force 256 correct rounds → `score` stays 255, `correct` still pulses.
- **Reset mid-round:** `rst_n`=0 during ARMED → next cycle IDLE, `score`=0, `lives`=0, no pulses; macro undefined with no submit for 10^4 cycles → remains ARMED, `timeout`=0.
